// File: rtl/mem_seq_rw.sv
// -----------------------------------------------------------------------------
// mem_seq_rw
//
// Memory write/readback sequencer. A rising edge on start (from IDLE or DONE)
// latches a pattern mode. The block then writes DEPTH words of that pattern to
// a 1-cycle-latency RAM, reads every word back and shows it on led for
// HOLD_CYCLES cycles. Any word that does not match the pattern sets err and
// bumps err_cnt.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    start request (level); only its rising edge acts
//   mode     pattern select, sampled on the start edge
//              0 thermometer, 1 count, 2 walking one, 3 checker
//   douta    RAM read data, valid one cycle after a read strobe
//   ena      RAM enable
//   wea      RAM write enable (only ever high together with ena)
//   addra    RAM address (always < DEPTH)
//   dina     RAM write data
//   led      last word read back
//   busy     high while writing or reading
//   done     high once the sequence has completed
//   err      sticky mismatch flag, cleared by the next start edge
//   err_cnt  number of mismatching words, saturating
//
// Every output comes straight from a flop. The next-state process computes
// the next value of each output together with the next state, so the outputs
// always describe the state that is currently registered.
// -----------------------------------------------------------------------------
module mem_seq_rw #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   douta,
  output logic                ena,
  output logic                wea,
  output logic [ADDR_W-1:0]   addra,
  output logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   led,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     err_cnt
);

  // The index is one bit wider than the address so that DEPTH = 2^ADDR_W
  // still reaches its last value without wrapping.
  localparam int IW   = ADDR_W + 1;
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [IW-1:0]   I_LAST = IW'(DEPTH - 1);
  localparam logic [HC_W-1:0] H_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_HOLD      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     i, i_n;
  logic [HC_W-1:0]   hold_cnt, hold_n;
  logic [1:0]        mode_q, mode_n;
  logic              start_q;
  logic              start_edge;

  logic              ena_n, wea_n, busy_n, done_n, err_n;
  logic [ADDR_W-1:0] addra_n;
  logic [DATA_W-1:0] dina_n, led_n;
  logic [ADDR_W:0]   err_cnt_n;

  assign start_edge = start & ~start_q;

  // Test pattern for word idx under pattern m.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m,
                                            input logic [IW-1:0] idx);
    logic [DATA_W-1:0] p;
    int                k;
    p = '0;
    k = int'(idx) % DATA_W;
    case (m)
      // Bits 0..idx set; saturates to all ones once idx reaches DATA_W-1.
      2'd0: for (int b = 0; b < DATA_W; b++) p[b] = (b <= int'(idx));
      2'd1: p = DATA_W'(idx) + DATA_W'(1);
      2'd2: for (int b = 0; b < DATA_W; b++) p[b] = (b == k);
      // Even words 10..10, odd words 01..01.
      default: for (int b = 0; b < DATA_W; b++)
                 p[b] = idx[0] ? (b % 2 == 0) : (b % 2 == 1);
    endcase
    return p;
  endfunction

  always_comb begin
    state_n   = state;
    i_n       = i;
    hold_n    = hold_cnt;
    mode_n    = mode_q;
    ena_n     = 1'b0;
    wea_n     = 1'b0;
    addra_n   = addra;
    dina_n    = dina;
    led_n     = led;
    err_n     = err;
    err_cnt_n = err_cnt;

    case (state)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_n   = S_WRITE;
          i_n       = '0;
          hold_n    = '0;
          mode_n    = mode;
          ena_n     = 1'b1;
          wea_n     = 1'b1;
          addra_n   = '0;
          dina_n    = pat(mode, '0);
          led_n     = '0;
          err_n     = 1'b0;
          err_cnt_n = '0;
        end
      end

      // The registered outputs already show word i; set up word i+1 or the
      // first read strobe.
      S_WRITE: begin
        ena_n = 1'b1;
        if (i == I_LAST) begin
          state_n = S_READ_REQ;
          i_n     = '0;
          addra_n = '0;
        end else begin
          i_n     = i + IW'(1);
          wea_n   = 1'b1;
          addra_n = i_n[ADDR_W-1:0];
          dina_n  = pat(mode_q, i_n);
        end
      end

      S_READ_REQ: begin
        state_n = S_READ_WAIT;
      end

      // douta is the word strobed in READ_REQ.
      S_READ_WAIT: begin
        led_n   = douta;
        state_n = S_HOLD;
        hold_n  = '0;
        if (douta != pat(mode_q, i)) begin
          err_n = 1'b1;
          if (err_cnt != '1) err_cnt_n = err_cnt + (ADDR_W+1)'(1);
        end
      end

      S_HOLD: begin
        if (hold_cnt == H_LAST) begin
          hold_n = '0;
          if (i < I_LAST) begin
            state_n = S_READ_REQ;
            i_n     = i + IW'(1);
            ena_n   = 1'b1;
            addra_n = i_n[ADDR_W-1:0];
          end else begin
            state_n = S_DONE;
          end
        end else begin
          hold_n = hold_cnt + HC_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_WRITE) || (state_n == S_READ_REQ) ||
             (state_n == S_READ_WAIT) || (state_n == S_HOLD);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      i        <= '0;
      hold_cnt <= '0;
      mode_q   <= '0;
      start_q  <= 1'b0;
      ena      <= 1'b0;
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      hold_cnt <= hold_n;
      mode_q   <= mode_n;
      start_q  <= start;
      ena      <= ena_n;
      wea      <= wea_n;
      addra    <= addra_n;
      dina     <= dina_n;
      led      <= led_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      err_cnt  <= err_cnt_n;
    end
  end

endmodule

// File: doc/mem_seq_rw.md
MEM_SEQ_RW -- requirements
Module: mem_seq_rw

Interface
REQ-001 Parameter DATA_W, default 16, is the memory word width and the LED width.
REQ-002 Parameter ADDR_W, default 4, is the memory address width.
REQ-003 Parameter DEPTH, default 16, is the number of words written and read; it SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004 Parameter HOLD_CYCLES, default 10_000_000, is the display hold per read word in clk cycles; it SHALL be >= 1.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port start, input, 1 bit: start request, level from a button; only its rising edge acts.
REQ-008 Port mode, input, 2 bits: pattern select, sampled on the start edge.
REQ-009 Port douta, input, DATA_W bits: memory read data, valid 1 cycle after a read strobe.
REQ-010 Port ena, output, 1 bit: memory enable.
REQ-011 Port wea, output, 1 bit: memory write enable.
REQ-012 Port addra, output, ADDR_W bits: memory address.
REQ-013 Port dina, output, DATA_W bits: memory write data.
REQ-014 Port led, output, DATA_W bits: displayed read word.
REQ-015 Port busy, output, 1 bit: high in WRITE and READ.
REQ-016 Port done, output, 1 bit: high in DONE.
REQ-017 Port err, output, 1 bit: sticky flag, set on any readback mismatch.
REQ-018 Port err_cnt, output, ADDR_W+1 bits: count of mismatching words, saturating.

Function
REQ-019 All outputs SHALL be registered; the states are IDLE, WRITE, READ_REQ, READ_WAIT, HOLD and DONE.
REQ-020 Start edge detection: edge = start & ~start_q, where start_q is start registered once.
REQ-021 In IDLE or DONE, an edge SHALL latch mode, clear err/err_cnt/led, set index i=0 and enter WRITE on the next cycle.
REQ-022 An edge in any other state SHALL be ignored.
REQ-023 In WRITE, each cycle SHALL drive ena=1, wea=1, addra=i, dina=pat(i) and then increment i.
REQ-024 After the cycle with i=DEPTH-1, WRITE SHALL go to READ_REQ with i=0; the write phase is exactly DEPTH cycles.
REQ-025 Pattern mode 0, thermometer: pat(i) = 2^(i+1)-1, saturating to all ones once i+1 >= DATA_W.
REQ-026 Pattern mode 1, count: pat(i) = i+1, zero-extended, then truncated to DATA_W.
REQ-027 Pattern mode 2, walking one: pat(i) = 1 << (i mod DATA_W).
REQ-028 Pattern mode 3, checker: pat(i) = alternating 10..10 for even i and 01..01 for odd i.
REQ-029 READ_REQ SHALL drive ena=1, wea=0, addra=i for exactly one cycle, then go to READ_WAIT.
REQ-030 READ_WAIT (ena=0) SHALL capture douta into led.
REQ-031 In READ_WAIT, if douta != pat(i), err SHALL be set and err_cnt incremented (held at all ones when saturated).
REQ-032 READ_WAIT SHALL then go to HOLD.
REQ-033 HOLD SHALL last exactly HOLD_CYCLES cycles with ena=0 and led stable.
REQ-034 At the end of HOLD, if i < DEPTH-1, i SHALL be incremented and the state SHALL return to READ_REQ; otherwise it SHALL go to DONE.
REQ-035 Per-word read period SHALL be HOLD_CYCLES+2 cycles.
REQ-036 In IDLE, DONE, READ_WAIT and HOLD: ena=0, wea=0, and addra/dina SHALL hold their last values.
REQ-037 In DONE, led SHALL keep the last word read, and err/err_cnt SHALL hold until the next start edge.
REQ-038 wea=1 SHALL never occur with ena=0.
REQ-039 No address >= DEPTH SHALL ever be driven.
REQ-040 The hold counter width SHALL be $clog2(HOLD_CYCLES+1); the index width SHALL be ADDR_W+1 so that DEPTH = 2^ADDR_W terminates without wrap.

Reset
REQ-041 While rst_n=0, all of the following SHALL be 0: state (IDLE), ena, wea, addra, dina, led, busy, done, err, err_cnt, i, hold counter, start_q and latched mode.
REQ-042 Reset SHALL take effect immediately, including mid-WRITE or mid-READ.
REQ-043 After reset is released, a new start edge is required; memory contents are not restored.

Verification (DATA_W=16, ADDR_W=4, DEPTH=16, HOLD_CYCLES=4, 1-cycle-latency RAM model)
REQ-044 Mode 0, pulse start: 16 write cycles with dina 0x0001, 0x0003 ... 0xFFFF. led then steps through the same values, each held 6 cycles. done=1, err=0, err_cnt=0, final led=0xFFFF.
REQ-045 Mode 2: dina sequence 0x0001, 0x0002 ... 0x8000. Mode 3: 0xAAAA / 0x5555 alternating. Both end with err=0.
REQ-046 Mode 1 with the RAM model corrupting address 5 (bit 0 flipped): led at word 5 = 0x0007, err=1 from that READ_WAIT onward, final err_cnt=1.
REQ-047 Start held high throughout, plus an extra pulse during READ: only one sequence runs. A new edge after done=1 restarts with err cleared.
REQ-048 rst_n pulsed low at write index 7: all outputs 0 within the same cycle, state stays IDLE with no further memory strobes until the next start edge.
